// File: rtl/hs_ctrl_pkg.sv
// hs_ctrl_pkg
// Shared types and helpers for the multi-channel req/busy/ack controller.
//   hs_state_e : controller FSM states
//   rr_pick    : round-robin index search over up to MAX_CH requesters
package hs_ctrl_pkg;

   localparam int MAX_CH = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SERVE = 2'd1,
      ACK   = 2'd2
   } hs_state_e;

   // First set request at or after ptr, wrapping at n_ch. The search runs
   // downward so the smallest offset from ptr is the last (winning) write.
   // Returns ptr when no request is set; callers gate with |req.
   function automatic logic [3:0] rr_pick(input logic [MAX_CH-1:0] req,
                                          input logic [3:0]        ptr,
                                          input int                n_ch);
      int idx;
      rr_pick = ptr;
      for (int k = MAX_CH - 1; k >= 0; k--) begin
         if (k < n_ch) begin
            idx = int'(ptr) + k;
            if (idx >= n_ch) idx = idx - n_ch;
            if (req[idx[3:0]]) rr_pick = idx[3:0];
         end
      end
   endfunction

endpackage

// File: rtl/multi_ch_hs_ctrl_if.sv
// multi_ch_hs_ctrl_if
// Handshake bundle between N_CH requesters / the service unit and the
// controller.
//   req    : per-channel request level       (master -> slave)
//   done   : service-complete pulse          (master -> slave)
//   busy   : resource owned                  (slave -> master)
//   id     : granted channel                 (slave -> master)
//   ack    : one-hot acknowledge             (slave -> master)
//   to_err : timeout pulse, only with HS_TIMEOUT_EN
interface multi_ch_hs_ctrl_if #(
   parameter int N_CH = 4,
   parameter int ID_W = $clog2(N_CH)
);
   logic [N_CH-1:0] req;
   logic            done;
   logic            busy;
   logic [ID_W-1:0] id;
   logic [N_CH-1:0] ack;
`ifdef HS_TIMEOUT_EN
   logic            to_err;

   modport master (output req, output done, input busy, input id, input ack, input to_err);
   modport slave  (input req, input done, output busy, output id, output ack, output to_err);
`else
   modport master (output req, output done, input busy, input id, input ack);
   modport slave  (input req, input done, output busy, output id, output ack);
`endif
endinterface

// File: rtl/multi_ch_hs_ctrl_arbiter.sv
// rr_arbiter
// Combinational round-robin pick among N_CH requests starting at i_ptr.
//   i_req       : request vector
//   i_ptr       : search start index
//   o_gnt_valid : any request present
//   o_gnt_id    : winning channel index
module rr_arbiter
   import hs_ctrl_pkg::*;
#(
   parameter int N_CH = 4,
   parameter int ID_W = $clog2(N_CH)
) (
   input  logic [N_CH-1:0] i_req,
   input  logic [ID_W-1:0] i_ptr,
   output logic            o_gnt_valid,
   output logic [ID_W-1:0] o_gnt_id
);
   logic [3:0] w_pick;

   always_comb w_pick = rr_pick(MAX_CH'(i_req), 4'(i_ptr), N_CH);

   assign o_gnt_valid = |i_req;
   assign o_gnt_id    = ID_W'(w_pick);
endmodule

// File: rtl/multi_ch_hs_ctrl.sv
// multi_ch_hs_ctrl
// N-channel round-robin req/busy/ack controller for one shared service unit.
// Optional SERVE timeout compiled in with macro HS_TIMEOUT_EN.
//   clk : clock, rising edge
//   rst : asynchronous active-high reset
//   hs  : slave side of multi_ch_hs_ctrl_if (req/done in, busy/id/ack[/to_err] out)
//
// state | meaning
// IDLE  | no owner; grant next requester from the round-robin pointer
// SERVE | owner holds the resource, waiting for done / abort / timeout
// ACK   | ack to owner, held until its req falls
module multi_ch_hs_ctrl
   import hs_ctrl_pkg::*;
#(
   parameter int N_CH      = 4,
   parameter int ID_W      = $clog2(N_CH),
   parameter int TO_CYCLES = 16
) (
   input logic                clk,
   input logic                rst,
   multi_ch_hs_ctrl_if.slave  hs
);
   hs_state_e       r_state, w_nxt;
   logic [ID_W-1:0] r_id, r_ptr, w_gnt_id, w_ptr_nxt;
   logic            w_gnt_valid, w_req_id, r_busy;
   logic [N_CH-1:0] r_ack;

   rr_arbiter #(.N_CH(N_CH), .ID_W(ID_W)) u_arb (
      .i_req       (hs.req),
      .i_ptr       (r_ptr),
      .o_gnt_valid (w_gnt_valid),
      .o_gnt_id    (w_gnt_id)
   );

   assign w_req_id  = hs.req[r_id];
   assign w_ptr_nxt = (r_id == ID_W'(N_CH - 1)) ? '0 : r_id + ID_W'(1);

`ifdef HS_TIMEOUT_EN
   localparam int CNT_W = $clog2(TO_CYCLES);
   logic [CNT_W-1:0] r_cnt;
   logic             w_take_to, r_to_err;
`endif

   always_comb begin
      w_nxt = r_state;
`ifdef HS_TIMEOUT_EN
      w_take_to = 1'b0;
`endif
      case (r_state)
         IDLE:  if (w_gnt_valid) w_nxt = SERVE;
         SERVE: begin
            // abort beats done, done beats timeout
            if (!w_req_id)   w_nxt = IDLE;
            else if (hs.done) w_nxt = ACK;
`ifdef HS_TIMEOUT_EN
            else if (r_cnt == CNT_W'(TO_CYCLES - 1)) begin
               w_nxt     = IDLE;
               w_take_to = 1'b1;
            end
`endif
         end
         ACK:   if (!w_req_id) w_nxt = IDLE;
         default: w_nxt = IDLE;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= IDLE;
         r_id    <= '0;
         r_ptr   <= '0;
         r_busy  <= 1'b0;
         r_ack   <= '0;
      end else begin
         r_state <= w_nxt;
         if (r_state == IDLE && w_gnt_valid) r_id <= w_gnt_id;
         if (r_state != IDLE && w_nxt == IDLE) r_ptr <= w_ptr_nxt;
         r_busy <= (w_nxt != IDLE);
         r_ack  <= (w_nxt == ACK) ? (N_CH'(1) << r_id) : '0;
      end
   end

`ifdef HS_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt    <= '0;
         r_to_err <= 1'b0;
      end else begin
         r_cnt    <= (r_state == SERVE) ? r_cnt + CNT_W'(1) : '0;
         r_to_err <= w_take_to;
      end
   end

   assign hs.to_err = r_to_err;
`endif

   assign hs.busy = r_busy;
   assign hs.id   = r_id;
   assign hs.ack  = r_ack;

`ifndef SYNTHESIS
   if (N_CH < 2 || N_CH > MAX_CH || TO_CYCLES < 2) begin : g_param_err
      $error("multi_ch_hs_ctrl: parameter out of range");
   end

   a_ack_onehot: assert property (@(posedge clk) disable iff (rst) $onehot0(hs.ack));
   a_ack_busy:   assert property (@(posedge clk) disable iff (rst) (|hs.ack) |-> hs.busy);
   a_busy_rise:  assert property (@(posedge clk) disable iff (rst)
                                  (r_state == IDLE && |hs.req) |=> hs.busy);
   a_ack_hold:   assert property (@(posedge clk) disable iff (rst)
                                  (|hs.ack && hs.req[hs.id]) |=> (hs.ack == $past(hs.ack)));
`endif
endmodule

// File: tb/tb_multi_ch_hs_ctrl.sv
module tb_multi_ch_hs_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_cmp = 0;
   int   n_bad = 0;

   typedef struct {
      int         cyc;
      logic [7:0] v;   // {busy, id[1:0], ack[3:0], to_err}
   } exp_t;
   exp_t exp_q[$];

   multi_ch_hs_ctrl_if #(.N_CH(4)) hs_if ();

   multi_ch_hs_ctrl #(.N_CH(4), .TO_CYCLES(16)) dut (
      .clk (clk),
      .rst (rst),
      .hs  (hs_if)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [7:0] tup(input logic b, input int ch, input logic [3:0] a, input logic te);
      return {b, 2'(ch), a, te};
   endfunction

   function automatic logic [7:0] cur_out();
      logic te;
`ifdef HS_TIMEOUT_EN
      te = hs_if.to_err;
`else
      te = 1'b0;
`endif
      return {hs_if.busy, hs_if.id, hs_if.ack, te};
   endfunction

   task automatic push(input int c, input logic [7:0] v);
      exp_t e;
      e.cyc = c;
      e.v   = v;
      exp_q.push_back(e);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every change of the output tuple must match the next
   // expected record, both in value and in cycle.
   logic [7:0] prev = 8'h00;
   always @(negedge clk) begin
      logic [7:0] cur;
      exp_t e;
      cur = cur_out();
      if (rst) begin
         prev = cur;
      end else if (cur !== prev) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL unexpected_change cyc=%0d actual=%b required=no change", cyc, cur);
         end else begin
            e = exp_q.pop_front();
            if (cur !== e.v || cyc != e.cyc) begin
               n_bad++;
               $display("FAIL out_tuple actual=%b@%0d required=%b@%0d", cur, cyc, e.v, e.cyc);
            end
         end
         prev = cur;
      end
   end

   // Entered in IDLE with ch the expected winner; serves it through ACK.
   task automatic serve_ch(input int ch, input int dly, input int hold, input bit stray,
                           input logic [3:0] req_drop, input logic [3:0] req_next);
      logic [3:0] oh;
      oh = 4'b0001 << ch;
      push(cyc + 1, tup(1'b1, ch, 4'b0000, 1'b0));
      step();
      repeat (dly) step();
      hs_if.done = 1'b1;
      push(cyc + 1, tup(1'b1, ch, oh, 1'b0));
      step();
      hs_if.done = 1'b0;
      for (int k = 0; k < hold; k++) begin
         if (stray) hs_if.done = 1'b1;
         step();
         hs_if.done = 1'b0;
      end
      hs_if.req = req_drop;
      push(cyc + 1, tup(1'b0, ch, 4'b0000, 1'b0));
      step();
      hs_if.req = req_next;
   endtask

   task automatic check_direct(input string name, input logic [7:0] req_v);
      logic [7:0] a;
      a = cur_out();
      n_cmp++;
      if (a !== req_v) begin
         n_bad++;
         $display("FAIL %s actual=%b required=%b", name, a, req_v);
      end
   endtask

   initial begin
      hs_if.req  = 4'b0000;
      hs_if.done = 1'b0;
      repeat (3) step();
      check_direct("reset_state", 8'h00);
      rst = 1'b0;

      // fairness: all four requesting, each served in turn
      hs_if.req = 4'b1111;
      serve_ch(0, 1, 0, 1'b0, 4'b1110, 4'b1111);
      serve_ch(1, 1, 0, 1'b0, 4'b1101, 4'b1111);
      serve_ch(2, 1, 0, 1'b0, 4'b1011, 4'b1111);
      serve_ch(3, 1, 0, 1'b0, 4'b0111, 4'b1111);
      serve_ch(0, 1, 0, 1'b0, 4'b1110, 4'b0000);
      step();

      // single channel, stray done while in ACK
      hs_if.req = 4'b0100;
      serve_ch(2, 2, 1, 1'b1, 4'b0000, 4'b0000);
      step();

      // abort of channel 1 coincident with done: abort wins, pointer -> 2
      hs_if.req = 4'b0010;
      push(cyc + 1, tup(1'b1, 1, 4'b0000, 1'b0));
      step();
      step();
      hs_if.req  = 4'b0000;
      hs_if.done = 1'b1;
      push(cyc + 1, tup(1'b0, 1, 4'b0000, 1'b0));
      step();
      hs_if.done = 1'b0;
      // stray done in IDLE
      hs_if.done = 1'b1;
      step();
      hs_if.done = 1'b0;
      step();
      // pointer=2 with requests 0,1,3 must pick 3
      hs_if.req = 4'b1011;
      serve_ch(3, 0, 0, 1'b0, 4'b0000, 4'b0000);
      step();

      // reset during ACK of channel 0
      hs_if.req = 4'b0001;
      push(cyc + 1, tup(1'b1, 0, 4'b0000, 1'b0));
      step();
      hs_if.done = 1'b1;
      push(cyc + 1, tup(1'b1, 0, 4'b0001, 1'b0));
      step();
      hs_if.done = 1'b0;
      step();
      rst = 1'b1;
      #1;
      check_direct("async_reset", 8'h00);
      hs_if.req = 4'b0011;
      step();
      rst = 1'b0;
      serve_ch(0, 0, 0, 1'b0, 4'b0000, 4'b0000);
      step();

`ifdef HS_TIMEOUT_EN
      // pointer=1, channel 2 times out after 16 SERVE cycles
      hs_if.req = 4'b0100;
      push(cyc + 1,  tup(1'b1, 2, 4'b0000, 1'b0));
      push(cyc + 17, tup(1'b0, 2, 4'b0000, 1'b1));
      push(cyc + 18, tup(1'b0, 2, 4'b0000, 1'b0));
      repeat (17) step();
      hs_if.req = 4'b0000;
      repeat (3) step();
      // done on the final count takes the ack path
      hs_if.req = 4'b1000;
      serve_ch(3, 15, 0, 1'b0, 4'b0000, 4'b0000);
      step();
`endif

      repeat (3) step();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL pending_expect actual=%0d left required=0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end
endmodule

// File: doc/multi_ch_hs_ctrl.md
# multi_ch_hs_ctrl

Parametrised N-channel req/busy/ack handshake controller, successor to the single-channel req/busy/ack block. It arbitrates round-robin among `N_CH` requesters and drives one shared service resource. While a channel is served it raises `busy` and presents the channel `id`, then returns a four-phase `ack` to the winner. It sits between requesting agents and a single downstream service unit that signals completion on `done`.

## Interface
- `N_CH`, 4: number of requesting channels (2..16).
- `ID_W`, `$clog2(N_CH)`: width of `id`.
- `TO_CYCLES`, 16: timeout limit in SERVE, in cycles (≥2). Used only with `HS_TIMEOUT_EN`.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  N_CH  per-channel request, level, held until acked.
- `done`  in  1  downstream service complete, one-cycle pulse.
- `busy`  out  1  resource owned by a channel.
- `id`  out  ID_W  granted channel index, valid while `busy`.
- `ack`  out  N_CH  one-hot acknowledge to the granted channel.
- `to_err`  out  1  one-cycle timeout pulse. Present only with `HS_TIMEOUT_EN`.

## Operation
- Reset values:
  - outputs: `busy`=0, `id`=0, `ack`=0, `to_err`=0;
  - internal: FSM=IDLE, round-robin pointer=0.
- States and transitions:
  - IDLE: if any `req` is set, grant the first channel at or after the pointer (wrapping) → SERVE. The grant is registered in `id`.
  - SERVE: `busy`=1.
    - `done`=1 → ACK.
    - `req[id]`=0 (requester abort) → IDLE with no ack.
    - With `HS_TIMEOUT_EN`: the cycle counter reaches `TO_CYCLES` → IDLE with `to_err` pulsed and no ack.
  - ACK: `busy`=1 and `ack[id]`=1. The state holds while `req[id]`=1. `req[id]`=0 → IDLE.
- Every exit from SERVE or ACK sets pointer = `id`+1 mod `N_CH`.
- `id` holds its value after returning to IDLE and updates only on a new grant.
- `done` outside SERVE is ignored.
- If `done` and abort occur in the same cycle in SERVE, abort wins.
- If `done` and timeout occur in the same cycle, `done` wins.
- A `req` arriving for another channel during SERVE or ACK is queued by level and is not lost.

## Timing
- All outputs are registered; there is no combinational input→output path.
- `req` sampled at edge k in IDLE → `busy`=1 and `id` valid from edge k+1. Grant latency is 1 cycle.
- `done` sampled at edge m → `ack` high from edge m+1.
- `req[id]` low sampled at edge p in ACK → `ack`=0 and `busy`=0 from edge p+1.
- The earliest next grant is 1 cycle after IDLE is entered, so there is at least one `busy`=0 cycle between grants.
- Timeout counter:
  - clears on entry to SERVE and increments each SERVE cycle;
  - the timeout fires on the cycle the count equals `TO_CYCLES`-1, so SERVE lasts exactly `TO_CYCLES` cycles;
  - `to_err` is high for exactly the first IDLE cycle.
- Asserting `rst` mid-operation immediately clears all outputs and state, with no ack and no `to_err`.

## Configuration
- Macro: `HS_TIMEOUT_EN`.
- Defined: the SERVE timeout counter, the `to_err` port and the timeout transition are compiled in.
- Undefined: there is no counter and no `to_err` port. SERVE waits indefinitely for `done` or abort.

## Structure
- Package `hs_ctrl_pkg` holds:
  - the state enum `hs_state_e` {IDLE, SERVE, ACK};
  - the function `rr_pick(req, ptr)` returning the next index.
- Sub-module `rr_arbiter` (`N_CH`): a combinational round-robin pick from `req` and the pointer, giving `gnt_valid` and `gnt_id`. The controller FSM, pointer, counter and output registers live in `multi_ch_hs_ctrl`.
- Embedded SVA, off in synthesis:
  - `ack` is one-hot-or-zero;
  - `ack` implies `busy`;
  - `busy` rises one cycle after a sampled `req`;
  - `ack` is held until `req[id]` falls.

## Test plan
- Single channel: `req[2]`=1 at cycle 1, `done` pulse at cycle 4 → `busy`=1 and `id`=2 from cycle 2, `ack`=4'b0100 from cycle 5. Drop `req[2]` at cycle 6 → `ack`=0 and `busy`=0 at cycle 7.
- Fairness: `req`=4'b1111 held with each served → grant order 0,1,2,3,0 with one idle cycle between grants.
- Abort: `req[1]` dropped in SERVE before `done` → IDLE next cycle, `ack` never asserts, pointer=2.
- Timeout (`HS_TIMEOUT_EN`, `TO_CYCLES`=16): no `done` → `busy` high for 16 cycles, then `to_err` one-cycle pulse, `ack`=0. In the same cycle as the final count `done`=1 → ack path is taken and `to_err`=0.
- Reset mid-ACK: `rst` pulsed while `ack`=4'b0001 → `ack`, `busy`, `id` and `to_err` are 0 asynchronously. After release with `req`=4'b0011 → channel 0 is granted.
- Stray `done` in IDLE or ACK → no state change and no spurious `ack`.
